inst_issuer: RTL and testbench

- Program sequencer that drives the enqueue (writer) side of a processor's control/instruction FIFO.
- Holds a small loadable program RAM of INST_WIDTH-bit instructions.
- On start, replays the first prog_len entries loop_count times into the FIFO, honouring ctrl_fifo_full backpressure.
- Sits between the testbench/host loader and a processor's ctrl_fifo_enq / ctrl_fifo_data_in / ctrl_fifo_full ports.

---
 rtl/inst_issuer.sv | 161 ++++++++++++++++
 tb/tb_inst_issuer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_issuer.sv
// Program sequencer that replays a loadable instruction RAM into a control FIFO.
// Optional stall statistics output enabled by defining INST_ISSUER_STALL_STATS_EN.
module inst_issuer #(
  parameter int unsigned INST_WIDTH      = 8,
  parameter int unsigned PROG_ADDR_WIDTH = 4,
  parameter int unsigned LOOP_WIDTH      = 8,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       prog_we,
  input  logic [PROG_ADDR_WIDTH-1:0] prog_addr,
  input  logic [INST_WIDTH-1:0]      prog_data,
  input  logic [PROG_ADDR_WIDTH:0]   prog_len,
  input  logic [LOOP_WIDTH-1:0]      loop_count,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_WIDTH-1:0]       issued_count,
  output logic                       ctrl_fifo_enq,
  output logic [INST_WIDTH-1:0]      ctrl_fifo_data_in,
  input  logic                       ctrl_fifo_full
`ifdef INST_ISSUER_STALL_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]       stall_count
`endif
);

  localparam int unsigned Depth = 2 ** PROG_ADDR_WIDTH;
  localparam logic [PROG_ADDR_WIDTH:0] MaxLen = {1'b1, {PROG_ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                     state_q, state_d;
  logic [PROG_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [LOOP_WIDTH-1:0]      iter_q, iter_d;
  logic [PROG_ADDR_WIDTH:0]   len_q, len_d;
  logic [LOOP_WIDTH-1:0]      passes_q, passes_d;
  logic [CNT_WIDTH-1:0]       issued_q, issued_d;
  logic [INST_WIDTH-1:0]      mem_q [Depth];

  logic start_ok;
  logic mem_we;
  logic last_pc;
  logic last_iter;

  assign start_ok  = (state_q == StIdle) && start;
  assign mem_we    = (state_q == StIdle) && prog_we;
  assign last_pc   = ({1'b0, pc_q} == (len_q - 1'b1));
  assign last_iter = (iter_q == (passes_q - 1'b1));

  // Program RAM is deliberately not reset so contents survive an abort.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (prog_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (ctrl_fifo_enq && last_pc && last_iter) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy              = (state_q == StRun);
    done              = (state_q == StDone);
    ctrl_fifo_enq     = (state_q == StRun) && !ctrl_fifo_full;
    ctrl_fifo_data_in = mem_q[pc_q];
  end

  // Datapath next state
  always_comb begin
    pc_d     = pc_q;
    iter_d   = iter_q;
    len_d    = len_q;
    passes_d = passes_q;
    issued_d = issued_q;
    if (start_ok) begin
      pc_d     = '0;
      iter_d   = '0;
      len_d    = (prog_len > MaxLen) ? MaxLen : prog_len;
      passes_d = (loop_count == '0) ? LOOP_WIDTH'(1) : loop_count;
    end else if (ctrl_fifo_enq) begin
      if (issued_q != '1) begin
        issued_d = issued_q + 1'b1;
      end
      if (last_pc) begin
        pc_d   = '0;
        iter_d = iter_q + 1'b1;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      iter_q   <= '0;
      len_q    <= '0;
      passes_q <= '0;
      issued_q <= '0;
    end else begin
      pc_q     <= pc_d;
      iter_q   <= iter_d;
      len_q    <= len_d;
      passes_q <= passes_d;
      issued_q <= issued_d;
    end
  end

  assign issued_count = issued_q;

`ifdef INST_ISSUER_STALL_STATS_EN
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_ok) begin
      stall_d = '0;
    end else if ((state_q == StRun) && ctrl_fifo_full && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_inst_issuer.sv
// Directed self-checking bench for inst_issuer; expected values are hand-computed.
module tb_inst_issuer;

  logic       clk;
  logic       reset;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [4:0] prog_len;
  logic [7:0] loop_count;
  logic       start;
  logic       busy;
  logic       done;
  logic [15:0] issued_count;
  logic       ctrl_fifo_enq;
  logic [7:0] ctrl_fifo_data_in;
  logic       ctrl_fifo_full;
`ifdef INST_ISSUER_STALL_STATS_EN
  logic [15:0] stall_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] prog3 [3] = '{8'hA1, 8'hB2, 8'hC3};
  logic [7:0] prog5 [5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};

  inst_issuer dut (
    .clk               (clk),
    .reset             (reset),
    .prog_we           (prog_we),
    .prog_addr         (prog_addr),
    .prog_data         (prog_data),
    .prog_len          (prog_len),
    .loop_count        (loop_count),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .issued_count      (issued_count),
    .ctrl_fifo_enq     (ctrl_fifo_enq),
    .ctrl_fifo_data_in (ctrl_fifo_data_in),
    .ctrl_fifo_full    (ctrl_fifo_full)
`ifdef INST_ISSUER_STALL_STATS_EN
    ,
    .stall_count       (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [3:0] addr, input logic [7:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic start_run(input logic [4:0] len, input logic [7:0] loops);
    prog_len   = len;
    loop_count = loops;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Expects n back-to-back enqueues of the 3-word program, then the done cycle.
  task automatic expect_burst3(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      check({tag, "_enq"}, 32'(ctrl_fifo_enq), 32'd1);
      check({tag, "_data"}, 32'(ctrl_fifo_data_in), 32'(prog3[i % 3]));
      tick();
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_enq_in_done"}, 32'(ctrl_fifo_enq), 32'd0);
    tick();
    check({tag, "_done_clear"}, 32'(done), 32'd0);
    check({tag, "_busy_clear"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    prog_we        = 1'b0;
    prog_addr      = '0;
    prog_data      = '0;
    prog_len       = '0;
    loop_count     = '0;
    start          = 1'b0;
    ctrl_fifo_full = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_enq", 32'(ctrl_fifo_enq), 32'd0);
    check("rst_issued", 32'(issued_count), 32'd0);
    #10 reset = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) write_word(4'(i), prog5[i]);

    // Two passes of a 3-word program
    start_run(5'd3, 8'd2);
    expect_burst3("loop2", 6);
    check("loop2_issued", 32'(issued_count), 32'd6);

    // loop_count of zero behaves as one pass
    start_run(5'd3, 8'd0);
    expect_burst3("loop0", 3);
    check("loop0_issued", 32'(issued_count), 32'd9);

    // Backpressure on RUN cycles 2-4
    start_run(5'd3, 8'd1);
    begin
      logic       full_pat [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [7:0] data_pat [6] = '{8'hA1, 8'hB2, 8'hB2, 8'hB2, 8'hB2, 8'hC3};
      for (int i = 0; i < 6; i++) begin
        ctrl_fifo_full = full_pat[i];
        #1;
        check("bp_enq", 32'(ctrl_fifo_enq), 32'(!full_pat[i]));
        check("bp_data", 32'(ctrl_fifo_data_in), 32'(data_pat[i]));
        tick();
      end
    end
    ctrl_fifo_full = 1'b0;
    check("bp_done", 32'(done), 32'd1);
    check("bp_issued", 32'(issued_count), 32'd12);
`ifdef INST_ISSUER_STALL_STATS_EN
    check("bp_stall_count", 32'(stall_count), 32'd3);
`endif
    tick();

    // Zero-length program: immediate done, nothing issued
    start_run(5'd0, 8'd4);
    check("len0_done", 32'(done), 32'd1);
    check("len0_enq", 32'(ctrl_fifo_enq), 32'd0);
    check("len0_busy", 32'(busy), 32'd0);
    tick();
    check("len0_done_clear", 32'(done), 32'd0);
    check("len0_issued", 32'(issued_count), 32'd12);

    // Abort mid-run after two issues
    start_run(5'd5, 8'd1);
    tick();
    tick();
    check("abort_pre_enq", 32'(ctrl_fifo_enq), 32'd1);
    check("abort_pre_issued", 32'(issued_count), 32'd14);
    reset = 1'b0;
    #1;
    check("abort_enq", 32'(ctrl_fifo_enq), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_issued", 32'(issued_count), 32'd0);
    #2 reset = 1'b1;
    tick();
    start_run(5'd5, 8'd1);
    for (int i = 0; i < 5; i++) begin
      check("restart_enq", 32'(ctrl_fifo_enq), 32'd1);
      check("restart_data", 32'(ctrl_fifo_data_in), 32'(prog5[i]));
      tick();
    end
    check("restart_done", 32'(done), 32'd1);
    check("restart_issued", 32'(issued_count), 32'd5);
    tick();

    // RAM writes during RUN are ignored
    start_run(5'd3, 8'd1);
    prog_we   = 1'b1;
    prog_addr = 4'd1;
    prog_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      check("we_run_data", 32'(ctrl_fifo_data_in), 32'(prog3[i]));
      tick();
    end
    prog_we = 1'b0;
    check("we_run_done", 32'(done), 32'd1);
    tick();
    start_run(5'd3, 8'd1);
    expect_burst3("we_after", 3);
    check("final_issued", 32'(issued_count), 32'd11);

    // Oversized prog_len clamps to the full RAM depth
    start_run(5'd31, 8'd1);
    for (int i = 0; i < 16; i++) tick();
    check("clamp_done", 32'(done), 32'd1);
    check("clamp_issued", 32'(issued_count), 32'd27);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
